clock_phase_select_ctrl: RTL and testbench

//  Sequencer for the 4-phase clock phaser (0/90/180/270). Accepts phase-change requests over
//  a valid/ready handshake and drives the phase mux select with glitch-safe gating: output

---
 rtl/clock_phase_pkg.sv | 29 ++
 rtl/phase_settle_timer.sv | 30 +++
 rtl/clock_phase_select_ctrl.sv | 132 +++++++++++++
 tb/tb_clock_phase_select_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_phase_pkg.sv
// Shared types and constants for the 4-phase clock phase selector.
// The optional PHASE_STEP_EN build uses step_toward() to walk one quadrant per switch.
package clock_phase_pkg;

    localparam int unsigned SETTLE_W = 8;

    typedef enum logic [1:0] {
        PH_0   = 2'd0,
        PH_90  = 2'd1,
        PH_180 = 2'd2,
        PH_270 = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        STARTUP  = 3'd0,
        IDLE     = 3'd1,
        GATE_OFF = 3'd2,
        SWITCH   = 3'd3,
        SETTLE   = 3'd4
    } ctrl_state_t;

    // One quadrant toward tgt along the shortest path; a 180deg delta goes up.
    function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
        logic [1:0] delta;
        delta = tgt - cur;
        return (delta == 2'd3) ? cur - 2'd1 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/phase_settle_timer.sv
// Load/count-down settle counter with a zero flag. Shared by the STARTUP,
// GATE_OFF and SETTLE windows; it parks at zero when not in use.
module phase_settle_timer
    import clock_phase_pkg::*;
#(
    parameter int unsigned RESET_VAL = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                cnt_zero
);

    logic [SETTLE_W-1:0] cnt_q;

    // Reset preloads the startup window; otherwise load or count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= SETTLE_W'(RESET_VAL);
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - SETTLE_W'(1);
        end
    end

    assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/clock_phase_select_ctrl.sv
// Glitch-safe sequencer for the 4-phase clock mux: gate off, settle, switch,
// settle, gate on. Optional macro PHASE_STEP_EN walks the select one quadrant
// per switch instead of jumping straight to the target.
module clock_phase_select_ctrl
    import clock_phase_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_phase,
    output logic       req_ready,
    output logic [1:0] phase_sel,
    output logic       gate_en,
    output logic       busy,
    output logic       done
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic [1:0]  phase_sel_q, phase_sel_d;
    logic [1:0]  target_q, target_d;
    logic        gate_en_q, gate_en_d;
    logic        done_q, done_d;
    logic        same_q, same_d;     // accepted request already matched; done follows next edge
    logic        tmr_load;
    logic        cnt_zero;
    logic [1:0]  next_phase;

    phase_settle_timer #(
        .RESET_VAL (SETTLE_CYCLES - 1)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (SettleLoad),
        .cnt_zero (cnt_zero)
    );

`ifdef PHASE_STEP_EN
    assign next_phase = step_toward(phase_sel_q, target_q);
`else
    assign next_phase = target_q;
`endif

    // State and output registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STARTUP;
            phase_sel_q <= 2'd0;
            target_q    <= 2'd0;
            gate_en_q   <= 1'b0;
            done_q      <= 1'b0;
            same_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_sel_q <= phase_sel_d;
            target_q    <= target_d;
            gate_en_q   <= gate_en_d;
            done_q      <= done_d;
            same_q      <= same_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        phase_sel_d = phase_sel_q;
        target_d    = target_q;
        gate_en_d   = gate_en_q;
        done_d      = same_q;
        same_d      = 1'b0;
        tmr_load    = 1'b0;
        case (state_q)
            STARTUP: begin
                if (cnt_zero) begin
                    gate_en_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    target_d = req_phase;
                    if (req_phase == phase_sel_q) begin
                        same_d = 1'b1;
                    end else begin
                        gate_en_d = 1'b0;
                        tmr_load  = 1'b1;
                        state_d   = GATE_OFF;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_zero) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                phase_sel_d = next_phase;
                tmr_load    = 1'b1;
                state_d     = SETTLE;
            end
            SETTLE: begin
                if (cnt_zero) begin
                    if (phase_sel_q == target_q) begin
                        gate_en_d = 1'b1;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = SWITCH;
                    end
                end
            end
            default: begin
                state_d = STARTUP;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign phase_sel = phase_sel_q;
    assign gate_en   = gate_en_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clock_phase_select_ctrl.sv
// Directed bench for clock_phase_select_ctrl with SETTLE_CYCLES=4.
// Expected timings are hand-derived from accept edge A.
module tb_clock_phase_select_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_phase;
    logic       req_ready;
    logic [1:0] phase_sel;
    logic       gate_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    clock_phase_select_ctrl #(
        .SETTLE_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_phase (req_phase),
        .req_ready (req_ready),
        .phase_sel (phase_sel),
        .gate_en   (gate_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) edge1();
    endtask

    initial begin
        int  found;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_phase = 2'd0;
        edges(2);

        // 1: reset values and startup window
        chk("rst_phase", 8'(phase_sel), 8'd0);
        chk("rst_gate", 8'(gate_en), 8'd0);
        chk("rst_ready", 8'(req_ready), 8'd0);
        chk("rst_busy", 8'(busy), 8'd1);
        chk("rst_done", 8'(done), 8'd0);
        rst = 1'b0;
        edges(3);
        chk("start_e3_gate", 8'(gate_en), 8'd0);
        chk("start_e3_ready", 8'(req_ready), 8'd0);
        edge1();
        chk("start_e4_gate", 8'(gate_en), 8'd1);
        chk("start_e4_ready", 8'(req_ready), 8'd1);
        chk("start_e4_busy", 8'(busy), 8'd0);

        // 2: 0 -> 1
        req_valid = 1'b1;
        req_phase = 2'd1;
        edge1();                                  // A
        req_valid = 1'b0;
        req_phase = 2'd2;                         // must be ignored
        chk("s2_A_gate", 8'(gate_en), 8'd0);
        chk("s2_A_ready", 8'(req_ready), 8'd0);
        edges(4);                                 // A+4
        chk("s2_A4_phase", 8'(phase_sel), 8'd0);
        edge1();                                  // A+5
        chk("s2_A5_phase", 8'(phase_sel), 8'd1);
        chk("s2_A5_gate", 8'(gate_en), 8'd0);
        edges(3);                                 // A+8
        chk("s2_A8_done", 8'(done), 8'd0);
        chk("s2_A8_gate", 8'(gate_en), 8'd0);
        edge1();                                  // A+9
        chk("s2_A9_gate", 8'(gate_en), 8'd1);
        chk("s2_A9_done", 8'(done), 8'd1);
        edge1();
        chk("s2_A10_done", 8'(done), 8'd0);
        chk("s2_A10_phase", 8'(phase_sel), 8'd1);

        // 3: request equals current phase
        req_valid = 1'b1;
        req_phase = 2'd1;
        edge1();                                  // A
        req_valid = 1'b0;
        chk("s3_A_done", 8'(done), 8'd0);
        chk("s3_A_gate", 8'(gate_en), 8'd1);
        chk("s3_A_ready", 8'(req_ready), 8'd1);
        edge1();
        chk("s3_A1_done", 8'(done), 8'd1);
        chk("s3_A1_gate", 8'(gate_en), 8'd1);
        chk("s3_A1_phase", 8'(phase_sel), 8'd1);
        edge1();
        chk("s3_A2_done", 8'(done), 8'd0);

        // 4: request held while busy
        req_valid = 1'b1;
        req_phase = 2'd2;
        edge1();                                  // A: 1 -> 2 accepted
        req_phase = 2'd3;                         // valid stays high
        for (int i = 1; i <= 8; i++) begin
            edge1();
            chk($sformatf("s4_ready_A%0d", i), 8'(req_ready), 8'd0);
        end
        edge1();                                  // A+9
        chk("s4_A9_phase", 8'(phase_sel), 8'd2);
        chk("s4_A9_done", 8'(done), 8'd1);
        chk("s4_A9_ready", 8'(req_ready), 8'd1);
        edge1();                                  // second accept
        req_valid = 1'b0;
        chk("s4_acc_gate", 8'(gate_en), 8'd0);
        chk("s4_acc_done", 8'(done), 8'd0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            edge1();
            if (done === 1'b1) found = 1;
        end
        chk("s4_done_seen", 8'(found), 8'd1);
        chk("s4_final_phase", 8'(phase_sel), 8'd3);
        chk("s4_final_gate", 8'(gate_en), 8'd1);

        // 5: reset during GATE_OFF
        edge1();
        req_valid = 1'b1;
        req_phase = 2'd0;
        edge1();                                  // A
        req_valid = 1'b0;
        edges(2);                                 // A+2
        #2;
        rst = 1'b1;
        #1;
        chk("s5_async_phase", 8'(phase_sel), 8'd0);
        chk("s5_async_gate", 8'(gate_en), 8'd0);
        chk("s5_async_ready", 8'(req_ready), 8'd0);
        chk("s5_async_busy", 8'(busy), 8'd1);
        edge1();
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            edge1();
            if (done === 1'b1) found = 1;
        end
        chk("s5_no_done", 8'(found), 8'd0);
        chk("s5_restart_gate", 8'(gate_en), 8'd1);
        chk("s5_restart_phase", 8'(phase_sel), 8'd0);

`ifdef PHASE_STEP_EN
        // 6: stepped walk 0 -> 2 goes through 1
        req_valid = 1'b1;
        req_phase = 2'd2;
        edge1();                                  // A
        req_valid = 1'b0;
        edges(5);
        chk("s6_A5_phase", 8'(phase_sel), 8'd1);
        chk("s6_A5_gate", 8'(gate_en), 8'd0);
        edges(4);
        chk("s6_A9_gate", 8'(gate_en), 8'd0);
        edge1();
        chk("s6_A10_phase", 8'(phase_sel), 8'd2);
        edges(3);
        chk("s6_A13_done", 8'(done), 8'd0);
        edge1();
        chk("s6_A14_gate", 8'(gate_en), 8'd1);
        chk("s6_A14_done", 8'(done), 8'd1);
        // 0 -> 3 steps down in one switch
        rst = 1'b1;
        edge1();
        rst = 1'b0;
        edges(4);
        req_valid = 1'b1;
        req_phase = 2'd3;
        edge1();                                  // A
        req_valid = 1'b0;
        edges(5);
        chk("s6b_A5_phase", 8'(phase_sel), 8'd3);
        edges(4);
        chk("s6b_A9_done", 8'(done), 8'd1);
        chk("s6b_A9_gate", 8'(gate_en), 8'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
